// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128 key expansion, one round key per handshake.
// Define KEY_SCHED_STORE_EN to add an 11-entry round-key store readable via rd_idx.
module aes_key_sched (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_data,
    output logic [7:0]   rcon_idx,
    input  logic [7:0]   rcon_val,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_data,
    output logic         keys_ready
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [127:0] w_q, w_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;
    logic         hs, last;
    logic [31:0]  t, n0, n1, n2, n3;

    assign hs   = (state_q == RUN) && rk_ready;
    assign last = rnd_q == 4'd10;

    // Next four words chain off each other: each is the previous new word XOR the old one.
    assign t  = sbox_out ^ {rcon_val, 24'h0};
    assign n0 = w_q[127:96] ^ t;
    assign n1 = w_q[95:64] ^ n0;
    assign n2 = w_q[63:32] ^ n1;
    assign n3 = w_q[31:0] ^ n2;

    assign busy     = state_q == RUN;
    assign rk_valid = busy;
    assign rk_idx   = busy ? rnd_q : 4'd0;
    assign rk_data  = busy ? w_q : 128'h0;
    assign done     = done_q;
    assign rcon_idx = (rnd_q < 4'd10) ? {4'h0, rnd_q + 4'd1} : 8'h00;
    assign sbox_in  = {w_q[23:0], w_q[31:24]};

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        rnd_d   = rnd_q;
        done_d  = hs && last;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            w_d     = key_in;
            rnd_d   = 4'd0;
        end else if (hs) begin
            state_d = last ? IDLE : RUN;
            w_d     = last ? w_q : {n0, n1, n2, n3};
            rnd_d   = last ? rnd_q : rnd_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

`ifdef KEY_SCHED_STORE_EN
    logic [127:0] store_q [11];
    logic         keys_ready_q, keys_ready_d;

    assign keys_ready_d = (state_q == IDLE && start) ? 1'b0 : (hs && last) ? 1'b1 : keys_ready_q;
    assign keys_ready   = keys_ready_q;
    assign rd_data      = (rd_idx <= 4'd10) ? store_q[rd_idx] : 128'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_ready_q <= 1'b0;
            for (int i = 0; i < 11; i++) store_q[i] <= '0;
        end else begin
            keys_ready_q <= keys_ready_d;
            if (hs) store_q[rnd_q] <= w_q;
        end
    end
`else
    logic unused_rd;
    assign unused_rd  = ^rd_idx;
    assign rd_data    = 128'h0;
    assign keys_ready = 1'b0;
`endif
endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: scoreboard bench with a FIPS-197 key-expansion reference model.
// Behavioural rcon and S-box (GF(2^8) inverse + affine map) feed the DUT's lookup ports.
module tb_aes_key_sched;
    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [127:0] key_in;
    logic         busy, done, rk_valid, keys_ready;
    logic [3:0]   rk_idx, rd_idx;
    logic [127:0] rk_data, rd_data;
    logic [7:0]   rcon_idx, rcon_val;
    logic [31:0]  sbox_in, sbox_out;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] data;
    } ent_t;

    ent_t         q[$];
    logic [127:0] cap [11];
    logic [127:0] model_rk [11];
    int checks = 0, fails = 0, n_done = 0, n_done_exp = 0, mode = 0, pcnt = 0;
    logic exp_done = 1'b0;

    always #5 clk = ~clk;

    aes_key_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy), .done(done),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx), .rk_data(rk_data),
        .rcon_idx(rcon_idx), .rcon_val(rcon_val), .sbox_in(sbox_in), .sbox_out(sbox_out),
        .rd_idx(rd_idx), .rd_data(rd_data), .keys_ready(keys_ready)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        logic [7:0] c;
        for (int k = 1; k < 256; k++) begin
            c = k[7:0];
            if (gmul(x, c) == 8'h01) v = c;
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    function automatic logic [7:0] rcon_f(input logic [7:0] i);
        logic [7:0] r = 8'h01;
        if (i == 8'h00) return 8'h00;
        for (int j = 1; j < int'(i); j++) r = xt(r);
        return r;
    endfunction

    assign rcon_val = rcon_f(rcon_idx);
    assign sbox_out = subword(sbox_in);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rcon_f(8'(i / 4)), 24'h0};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) begin
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            q.push_back('{idx: 4'(r), data: model_rk[r]});
        end
    endtask

    task automatic go(input logic [127:0] k);
        for (int i = 0; i < 100 && busy; i++) @(posedge clk) #1;
        if (busy) chk("idle_timeout", 1, 0);
        key_in = k;
        push_model(k);
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 200 && !done; i++) @(posedge clk) #1;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_idx(input logic [3:0] n);
        int i;
        for (i = 0; i < 200 && !(busy && rk_idx == n); i++) @(posedge clk) #1;
        if (!(busy && rk_idx == n)) chk("idx_timeout", {124'h0, rk_idx}, {124'h0, n});
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_idx", rk_idx, 0);
        chk("rst_data", rk_data, 0);
        chk("rst_keys_ready", keys_ready, 0);
        chk("rst_rd_data", rd_data, 0);
    endtask

    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk) #1;
            case (mode)
                0: rk_ready = 1'b1;
                1: begin rk_ready = (pcnt % 3 == 0); pcnt++; end
                default: rk_ready = 1'($urandom % 2);
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) exp_done = 1'b0;
        else begin
            if (done) n_done++;
            if (done || exp_done) begin
                chk("done_pulse", done, exp_done);
                chk("busy_at_done", busy, 0);
            end
            exp_done = 1'b0;
            if (rk_valid) begin
                if (q.size() == 0) chk("unexpected_key", {124'h0, rk_idx}, 128'hx);
                else begin
                    chk("rk_idx", rk_idx, q[0].idx);
                    chk("rk_data", rk_data, q[0].data);
                    chk("rcon_idx", rcon_idx, (q[0].idx < 10) ? q[0].idx + 1 : 0);
                    chk("sbox_in", sbox_in, {q[0].data[23:0], q[0].data[31:24]});
                    if (rk_ready) begin
                        cap[q[0].idx] = rk_data;
                        if (q[0].idx == 4'd10) begin
                            exp_done = 1'b1;
                            n_done_exp++;
                        end
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [127:0] fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rst_n = 1'b0; start = 1'b0; key_in = '0; rd_idx = '0;
        repeat (2) @(posedge clk);
        #1 chk_reset_vals();
        rst_n = 1'b1;
        @(posedge clk) #1;

        go(fips);
        chk("first_idx", {124'h0, rk_idx}, 0);
        wait_done();
        @(posedge clk) #1;
        chk("fips_r1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_r10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`ifdef KEY_SCHED_STORE_EN
        chk("keys_ready_set", keys_ready, 1);
        rd_idx = 4'd1;  #1 chk("rd_1", rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10; #1 chk("rd_10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx = 4'd15; #1 chk("rd_15", rd_data, 128'h0);
        rd_idx = 4'd5;  #1 chk("rd_5", rd_data, model_rk[5]);
`endif

        mode = 1; pcnt = 0;
        go(fips);
`ifdef KEY_SCHED_STORE_EN
        chk("keys_ready_clr", keys_ready, 0);
`endif
        wait_done();

        mode = 2;
        go({$urandom, $urandom, $urandom, $urandom});
        wait_idx(4'd4);
        key_in = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        wait_done();

        mode = 0;
        go({$urandom, $urandom, $urandom, $urandom});
        wait_idx(4'd6);
        rst_n = 1'b0;
        #1 chk_reset_vals();
        q.delete();
        @(posedge clk) #1;
        rst_n = 1'b1;
        go(128'h000102030405060708090a0b0c0d0e0f);
        wait_done();
        @(posedge clk) #1;
        chk("seq_r10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        go({$urandom, $urandom, $urandom, $urandom});
        wait_done();
        go({$urandom, $urandom, $urandom, $urandom});
        chk("b2b_busy", busy, 1);
        chk("b2b_idx", {124'h0, rk_idx}, 0);
        wait_done();

        mode = 2;
        for (int n = 0; n < 4; n++) begin
            go({$urandom, $urandom, $urandom, $urandom});
            wait_done();
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", n_done, n_done_exp);
        chk("queue_empty", q.size(), 0);
`ifndef KEY_SCHED_STORE_EN
        chk("no_store_ready", keys_ready, 0);
        chk("no_store_rd", rd_data, 0);
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Iterative AES-128 key-expansion controller. It takes a 128-bit cipher key and produces round keys 0..10 one at a time, with a valid/ready handshake. It sequences the shared round-constant LUT (index 1..10) and an external 4-byte S-box word lookup. It sits between the key-load interface and the round datapath. An optional 11-entry round-key store lets the cipher core re-read keys without re-expanding.

## Interface
- No parameters; widths are fixed by AES-128.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to expand key_in; honoured only in IDLE
- key_in  input  128  cipher key; sampled on an accepted start; bits [127:96] = w0
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse after round key 10 is accepted
- rk_valid  output  1  rk_data/rk_idx are valid
- rk_ready  input  1  consumer accepts the current round key
- rk_idx  output  4  round index 0..10 of rk_data
- rk_data  output  128  current round key (w4r..w4r+3, MSW first)
- rcon_idx  output  8  index to the rcon LUT: rnd+1 when rnd<10, else 8'h00
- rcon_val  input  8  rcon LUT output, combinational from rcon_idx
- sbox_in  output  32  RotWord(w3) = {w3[23:0], w3[31:24]}
- sbox_out  input  32  bytewise S-box of sbox_in, combinational
- rd_idx  input  4  store read index (KEY_SCHED_STORE_EN only)
- rd_data  output  128  stored round key for rd_idx
- keys_ready  output  1  store holds a complete key set

## Operation
- States: IDLE, RUN. Registers: w_reg[127:0], rnd[3:0].
- IDLE, start=1: w_reg <= key_in, rnd <= 0, go to RUN, keys_ready <= 0.
- RUN:
  - rk_valid=1, rk_data=w_reg, rk_idx=rnd.
  - Handshake = rk_valid & rk_ready.
  - Handshake with rnd<10: w_reg <= next(w_reg), rnd <= rnd+1.
  - Handshake with rnd==10: go to IDLE; done pulses the next cycle.
  - No handshake: hold everything; rk_data stays stable.
- next(): t = sbox_out ^ {rcon_val, 24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. All XOR, no carries.
- start in RUN is ignored; the current expansion completes unchanged.
- rcon_idx and sbox_in are combinational from w_reg/rnd and are driven in every state.

## Timing
- Reset values: busy=0, done=0, rk_valid=0, rk_idx=0, rk_data=0, keys_ready=0, rd_data=0, state=IDLE.
- Inputs sampled on rising edge: start at edge T → busy=1 and rk_valid=1 with rk_idx=0 after T.
- With rk_ready held high, keys 0..10 appear on 11 consecutive cycles. done is high in the cycle after the key-10 handshake, with busy=0.
- A new start is accepted in the same cycle done is high (state is IDLE).
- Back-to-back: minimum start-to-start spacing is 12 cycles.
- rst_n low mid-RUN: immediate return to IDLE, all outputs to reset values, store contents invalidated (keys_ready=0). No done pulse.

## Configuration
- KEY_SCHED_STORE_EN defined:
  - An 11×128 register array captures each round key on its handshake.
  - keys_ready is set together with done and cleared on the next accepted start or reset.
  - rd_data = store[rd_idx], combinational; rd_idx>10 returns 128'h0.
- KEY_SCHED_STORE_EN undefined: no array; rd_data tied to 0; keys_ready tied to 0; rd_idx ignored.

## Test plan
- Bench instantiates the team's rcon and S-box. Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk_idx 0..10 on consecutive cycles. Round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. done one cycle later.
- Same key with rk_ready toggling 1,0,0,1... → identical key sequence; rk_data stable while ready=0; rcon_idx observed 01..0A then 00.
- start pulsed at rnd=4 with a different key_in → ignored; sequence completes with the original key.
- rst_n asserted at rnd=6 → outputs at reset values, no done. A new start with key 000102030405060708090a0b0c0d0e0f gives round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- KEY_SCHED_STORE_EN: after the FIPS key, rd_idx=1 → a0fafe17…7605; rd_idx=10 → d014f9a8…0ca6; rd_idx=15 → 0. keys_ready drops on the next start.
- start asserted in the done cycle → accepted; the second expansion begins the next cycle with rk_idx=0.
